// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl
// Time-multiplexed scan controller for NDIG seven-segment digits that share
// one bcd7seg decoder. The core writes BCD values into a small register file;
// the scanner walks the digits with a fixed dwell per slot. Each slot opens
// with an all-off guard interval to suppress ghosting, then lights its digit.
// Outputs are decoded purely from registers, so there is no input-to-output
// path and en/blank_lz/writes reach the pins with one cycle of latency.

module seg7_scan_ctrl #(
  parameter int NDIG  = 8,
  parameter int DIV   = 1000,
  parameter int GUARD = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    blank_lz,
  input  logic                    wr_en,
  input  logic [$clog2(NDIG)-1:0] wr_idx,
  input  logic [3:0]              wr_data,
  output logic [3:0]              bcd_o,
  output logic [NDIG-1:0]         an_o,
  output logic                    frame_o
);

  // Index and dwell-counter widths; DIV of 1 still needs a one-bit counter.
  localparam int IW = $clog2(NDIG);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [CW-1:0]   CNT_ZERO = CW'(0);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DIV - 1);
  localparam logic [IW-1:0]   IDX_ZERO = IW'(0);
  localparam logic [IW-1:0]   IDX_ONE  = IW'(1);
  localparam logic [IW-1:0]   IDX_LAST = IW'(NDIG - 1);
  localparam logic [NDIG-1:0] AN_OFF   = {NDIG{1'b1}};

  // Architectural state.
  logic [3:0]    dig_r [NDIG];
  logic [IW-1:0] idx_r;
  logic [CW-1:0] cnt_r;
  logic          frame_r;
  logic          en_r;
  logic          blank_r;

  // Next-state values.
  logic [3:0]    dig_s [NDIG];
  logic [IW-1:0] idx_s;
  logic [CW-1:0] cnt_s;
  logic          frame_s;

  // Decode helpers.
  logic            slot_end_s;
  logic            last_slot_s;
  logic            show_s;
  logic            wr_ok_s;
  logic            zero_tail_s;
  logic [NDIG-1:0] blanked_s;
  logic [NDIG-1:0] an_s;
  logic [3:0]      bcd_s;

  // Slot boundary, frame wrap and phase decode from the dwell counter.
  always_comb begin
    slot_end_s  = (cnt_r == CNT_LAST);
    last_slot_s = (idx_r == IDX_LAST);
    // SHOW once the counter has passed the guard window; GUARD of 0 means always SHOW.
    show_s      = (32'(cnt_r) >= 32'(GUARD));
    // Out-of-range indices only exist for non-power-of-two NDIG; they are dropped.
    if (wr_en) begin
      wr_ok_s = (32'(wr_idx) < 32'(NDIG));
    end else begin
      wr_ok_s = 1'b0;
    end
  end

  // Next scan position, frame strobe and register-file contents.
  always_comb begin
    idx_s   = idx_r;
    cnt_s   = cnt_r;
    frame_s = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      dig_s[i] = dig_r[i];
    end

    if (slot_end_s) begin
      cnt_s = CNT_ZERO;
      if (last_slot_s) begin
        idx_s   = IDX_ZERO;
        frame_s = 1'b1;
      end else begin
        idx_s   = idx_r + IDX_ONE;
        frame_s = 1'b0;
      end
    end else begin
      cnt_s = cnt_r + CNT_ONE;
    end

    // A write landing on a slot advance is visible through the new idx at once,
    // since both take effect on the same edge and bcd_o reads the updated file.
    for (int i = 0; i < NDIG; i++) begin
      if (wr_ok_s && (wr_idx == IW'(i))) begin
        dig_s[i] = wr_data;
      end else begin
        dig_s[i] = dig_r[i];
      end
    end
  end

  // State registers with synchronous reset; reset mid-slot restarts at digit 0 in GUARD.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r   <= IDX_ZERO;
      cnt_r   <= CNT_ZERO;
      frame_r <= 1'b0;
      en_r    <= 1'b0;
      blank_r <= 1'b0;
      for (int i = 0; i < NDIG; i++) begin
        dig_r[i] <= 4'd0;
      end
    end else begin
      idx_r   <= idx_s;
      cnt_r   <= cnt_s;
      frame_r <= frame_s;
      en_r    <= en;
      blank_r <= blank_lz;
      for (int i = 0; i < NDIG; i++) begin
        dig_r[i] <= dig_s[i];
      end
    end
  end

  // Leading-zero blanking: walk from the top digit down, tracking whether every
  // digit at or above the current one is zero. Digit 0 always stays visible.
  always_comb begin
    zero_tail_s = 1'b1;
    blanked_s   = {NDIG{1'b0}};
    for (int i = NDIG - 1; i >= 0; i--) begin
      zero_tail_s = zero_tail_s && (dig_r[i] == 4'd0);
      if (i != 0) begin
        blanked_s[i] = blank_r && zero_tail_s;
      end else begin
        blanked_s[i] = 1'b0;
      end
    end
  end

  // Digit-enable decode: at most one active-low bit, only in SHOW with display enabled.
  always_comb begin
    an_s = AN_OFF;
    if (show_s && en_r) begin
      for (int i = 0; i < NDIG; i++) begin
        if ((idx_r == IW'(i)) && !blanked_s[i]) begin
          an_s[i] = 1'b0;
        end else begin
          an_s[i] = 1'b1;
        end
      end
    end else begin
      an_s = AN_OFF;
    end
  end

  // Shared decoder input follows the current slot's digit, guard phase included.
  always_comb begin
    bcd_s = 4'd0;
    for (int i = 0; i < NDIG; i++) begin
      if (idx_r == IW'(i)) begin
        bcd_s = dig_r[i];
      end else begin
        bcd_s = bcd_s;
      end
    end
  end

  assign bcd_o   = bcd_s;
  assign an_o    = an_s;
  assign frame_o = frame_r;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl (NDIG=4, DIV=8, GUARD=2).
// Stimulus is applied on the falling edge; a reference model written in terms
// of elapsed cycles since reset predicts the outputs after the next rising edge
// and queues them. A monitor pops one expectation per rising edge.

module tb_seg7_scan_ctrl;

  localparam int NDIG  = 4;
  localparam int DIV   = 8;
  localparam int GUARD = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       blank_lz;
  logic       wr_en;
  logic [1:0] wr_idx;
  logic [3:0] wr_data;
  logic [3:0] bcd_o;
  logic [3:0] an_o;
  logic       frame_o;

  seg7_scan_ctrl #(.NDIG(NDIG), .DIV(DIV), .GUARD(GUARD)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .blank_lz(blank_lz),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_data (wr_data),
    .bcd_o   (bcd_o),
    .an_o    (an_o),
    .frame_o (frame_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] bcd;
    logic [3:0] an;
    logic       fr;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Reference model: t counts cycles since reset release (slot/position follow by division).
  int t;
  int mdig [NDIG];
  bit men;
  bit mbl;
  bit mfr;

  function automatic exp_t predict();
    exp_t x;
    int   slot;
    int   pos;
    bit   zt;
    bit   blanked;
    slot  = (t / DIV) % NDIG;
    pos   = t % DIV;
    x.bcd = 4'(mdig[slot]);
    x.an  = 4'b1111;
    x.fr  = mfr;
    zt = 1'b1;
    for (int j = slot; j < NDIG; j++) begin
      if (mdig[j] != 0) zt = 1'b0;
    end
    blanked = mbl && (slot != 0) && zt;
    if (pos >= GUARD && men && !blanked) x.an[slot] = 1'b0;
    return x;
  endfunction

  task automatic step(input bit r, input bit e, input bit b, input bit we, input int wi, input int wd);
    @(negedge clk);
    rst      = r;
    en       = e;
    blank_lz = b;
    wr_en    = we;
    wr_idx   = 2'(wi);
    wr_data  = 4'(wd);
    if (r) begin
      t   = 0;
      men = 1'b0;
      mbl = 1'b0;
      mfr = 1'b0;
      for (int i = 0; i < NDIG; i++) mdig[i] = 0;
    end else begin
      mfr = ((t + 1) % (NDIG * DIV)) == 0;
      t   = t + 1;
      men = e;
      mbl = b;
      if (we && wi < NDIG) mdig[wi] = wd & 15;
    end
    q.push_back(predict());
  endtask

  // Monitor: one expectation is consumed per rising edge, sampled 1 time unit later.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (q.size() > 0) begin
        exp_t x;
        x = q.pop_front();
        checks++;
        if (bcd_o !== x.bcd) begin
          errors++;
          $display("FAIL bcd_o cycle %0d got %0d expected %0d", cyc, bcd_o, x.bcd);
        end
        checks++;
        if (an_o !== x.an) begin
          errors++;
          $display("FAIL an_o cycle %0d got %b expected %b", cyc, an_o, x.an);
        end
        checks++;
        if (frame_o !== x.fr) begin
          errors++;
          $display("FAIL frame_o cycle %0d got %b expected %b", cyc, frame_o, x.fr);
        end
      end
    end
  end

  initial begin
    bit ren;
    bit rbl;
    rst = 1'b1; en = 1'b1; blank_lz = 1'b0; wr_en = 1'b0; wr_idx = 2'd0; wr_data = 4'd0;
    t = 0; men = 1'b0; mbl = 1'b0; mfr = 1'b0;
    for (int i = 0; i < NDIG; i++) mdig[i] = 0;

    // Reset held three cycles, then basic scan of 0,1,2,3.
    repeat (3) step(1, 1, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0);
    step(0, 1, 0, 1, 1, 1);
    step(0, 1, 0, 1, 2, 2);
    step(0, 1, 0, 1, 3, 3);
    repeat (70) step(0, 1, 0, 0, 0, 0);

    // Leading-zero blanking with {0,0,5,0}, then all zero.
    step(0, 1, 1, 1, 3, 0);
    step(0, 1, 1, 1, 2, 0);
    step(0, 1, 1, 1, 1, 5);
    step(0, 1, 1, 1, 0, 0);
    repeat (40) step(0, 1, 1, 0, 0, 0);
    step(0, 1, 1, 1, 1, 0);
    repeat (40) step(0, 1, 1, 0, 0, 0);

    // Write to the live digit during SHOW of digit 1.
    step(0, 1, 0, 1, 1, 4);
    for (int k = 0; k < 64 && !(((t / DIV) % NDIG) == 1 && (t % DIV) == 4); k++) step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 1, 1, 9);
    repeat (20) step(0, 1, 0, 0, 0, 0);

    // Enable gating mid-slot, then resume.
    repeat (5) step(0, 0, 0, 0, 0, 0);
    repeat (20) step(0, 1, 0, 0, 0, 0);

    // Out-of-range BCD value passes through.
    step(0, 1, 0, 1, 0, 12);
    repeat (20) step(0, 1, 0, 0, 0, 0);

    // Reset at idx=2, cnt=5.
    for (int k = 0; k < 64 && (t % (NDIG * DIV)) != (2 * DIV + 5); k++) step(0, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    repeat (20) step(0, 1, 0, 0, 0, 0);

    // Randomized traffic.
    ren = 1'b1;
    rbl = 1'b0;
    repeat (3000) begin
      if ($urandom_range(0, 24) == 0) ren = ~ren;
      if ($urandom_range(0, 49) == 0) rbl = ~rbl;
      step($urandom_range(0, 399) == 0, ren, rbl,
           $urandom_range(0, 5) == 0,
           int'($urandom_range(0, NDIG - 1)),
           ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, 15)));
    end

    step(0, 1, 0, 0, 0, 0);
    @(posedge clk);
    #3;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
